// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b types for the fetch stage: machine word, fetch
//               FSM state encoding, reset PC constant and the prefetch
//               buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_RESET_PC = 16'h0000;

  // One prefetched instruction together with the PC value the datapath
  // uses as its PC-relative base (address of the word + 2).
  typedef struct packed {
    lc3b_word word;
    lc3b_word pc_next;
  } lc3b_fetch_entry;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO holding prefetched instruction
//               entries. Flush has priority over push and pop.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               i_push, i_din   - write an entry
//               i_pop           - remove the head entry (ignored when empty)
//               i_flush         - discard all entries
//               o_dout          - head entry (all zero when empty)
//               o_count         - number of stored entries
//               o_empty         - no entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  lc3b_fetch_entry            i_din,
  output lc3b_fetch_entry            o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  lc3b_fetch_entry r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;

  logic w_push;
  logic w_pop;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // naturally without a compare.
  assign w_pop  = i_pop  & (r_count != '0);
  assign w_push = i_push & (r_count != c_FULL);

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/lc3b_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_fetch_unit
// Description : LC-3b instruction-fetch stage. Owns the fetch PC, issues
//               word reads on a held-request memory handshake, buffers the
//               returned words and presents them to the IR with valid/ready.
//               A redirect flushes the buffer and restarts fetch.
// Ports       : clk, rst_n                    - clock, sync active-low reset
//               i_redirect, i_redirect_pc     - flush and refetch request
//               i_instr_ready                 - IR accepts head word
//               o_instr, o_instr_pc_next      - head word and its PC + 2
//               o_instr_valid                 - buffer non-empty
//               o_mem_read, o_mem_address     - memory read request
//               i_mem_resp, i_mem_rdata       - memory read completion
//               o_fetch_busy                  - request outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_fetch_unit
  import lc3b_types::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = LC3B_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_instr_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc_next,
  output logic        o_instr_valid,
  output logic        o_mem_read,
  output logic [15:0] o_mem_address,
  input  logic        i_mem_resp,
  input  logic [15:0] i_mem_rdata,
  output logic        o_fetch_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  lc3b_fetch_state r_state;
  lc3b_word        r_fetch_pc;
  // Address presented to memory. Separate from r_fetch_pc because a
  // redirect during an outstanding request must leave the old address
  // on the bus until the response arrives.
  lc3b_word        r_mem_addr;

  lc3b_fetch_entry w_din;
  lc3b_fetch_entry w_dout;
  logic [AW:0]     w_count;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_room;
  logic            w_room_after_push;
  lc3b_word        w_target;
  lc3b_word        w_pc_plus2;

  assign w_target   = {i_redirect_pc[15:1], 1'b0};
  assign w_pc_plus2 = r_fetch_pc + 16'd2;

  assign w_pop  = ~w_empty & i_instr_ready & ~i_redirect;
  assign w_push = (r_state == S_FETCH) & i_mem_resp & ~i_redirect;

  assign w_din.word    = i_mem_rdata;
  assign w_din.pc_next = w_pc_plus2;

  // Room is judged on the occupancy before this cycle's pop. After a push
  // there is still room if either a pop frees a slot or the buffer held
  // fewer than DEPTH-1 entries.
  assign w_room            = (w_count < c_FULL);
  assign w_room_after_push = w_pop | (w_count < (c_FULL - 1'b1));

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
    end else if (i_redirect) begin
      r_fetch_pc <= w_target;
      case (r_state)
        S_FETCH: begin
          if (i_mem_resp) begin
            // Response for the old stream is dropped; issue the new one.
            r_state    <= S_FETCH;
            r_mem_addr <= w_target;
          end else begin
            r_state <= S_DROP;
          end
        end
        S_DROP: r_state <= S_DROP;
        default: begin
          r_state    <= S_FETCH;
          r_mem_addr <= w_target;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_room) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_mem_resp) begin
            r_fetch_pc <= w_pc_plus2;
            r_mem_addr <= w_pc_plus2;
            r_state    <= w_room_after_push ? S_FETCH : S_IDLE;
          end
        end
        S_DROP: begin
          // Stale response discarded; r_fetch_pc already holds the target.
          if (i_mem_resp) begin
            r_state    <= S_FETCH;
            r_mem_addr <= r_fetch_pc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_read      = (r_state != S_IDLE);
  assign o_fetch_busy    = (r_state != S_IDLE);
  assign o_mem_address   = r_mem_addr;
  assign o_instr_valid   = ~w_empty;
  assign o_instr         = w_dout.word;
  assign o_instr_pc_next = w_dout.pc_next;

endmodule
`default_nettype wire

// File: doc/lc3b_fetch_unit.md
Name: lc3b_fetch_unit

Overview:
- Instruction-fetch stage that directly feeds the instruction register.
- Owns the fetch PC and issues word reads on the memory handshake (mem_read held until mem_resp).
- Places returned words in a small prefetch buffer and presents them to the IR with a valid/ready handshake; the IR's load strobe is instr_valid & instr_ready.
- A redirect from the datapath (branch, JMP, JSR, TRAP, RET) flushes the buffer and restarts fetch at a new PC.

Parameters:
- DEPTH, 2, prefetch buffer entries (power of 2, 2..8).
- RESET_PC, 16'h0000, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- redirect  in  1  one-cycle request to flush and refetch from redirect_pc.
- redirect_pc  in  16  new fetch address (lc3b_word); bit 0 is ignored and forced to 0.
- instr_ready  in  1  consumer (IR load) accepts the head word this cycle.
- instr  out  16  head-of-buffer instruction word.
- instr_pc_next  out  16  address of head word + 2 (LC-3b PC-relative base).
- instr_valid  out  1  buffer non-empty.
- mem_read  out  1  memory read request; held until mem_resp.
- mem_address  out  16  read address; stable while mem_read=1.
- mem_resp  in  1  one-cycle read completion.
- mem_rdata  in  16  read data, valid with mem_resp.
- fetch_busy  out  1  request outstanding (state != S_IDLE).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - fetch_pc=RESET_PC; buffer empty; state=S_IDLE.
  - mem_read=0, mem_address=RESET_PC, instr_valid=0, instr=0, instr_pc_next=0, fetch_busy=0.
  - Reset mid-request abandons the request: the next mem_resp is ignored while in S_IDLE.
- States:
  - S_IDLE: mem_read=0. Go to S_FETCH if count<DEPTH (count measured before any pop this cycle) and no redirect.
  - S_FETCH: mem_read=1, mem_address=fetch_pc.
    - On mem_resp without redirect: push {mem_rdata, fetch_pc+2}; fetch_pc+=2 (mod 2^16; 16'hFFFE wraps to 16'h0000).
    - After the push, return to S_FETCH if post-push count<DEPTH, else S_IDLE. Back-to-back requests are allowed: mem_read may stay high continuously.
  - S_DROP: a redirect arrived while a request was outstanding. mem_read stays 1 at the old address (the memory cannot be cancelled). On mem_resp, discard data and go to S_FETCH at the already-loaded fetch_pc.
- Redirect (any state):
  - Buffer cleared the same edge; fetch_pc=redirect_pc&16'hFFFE.
  - S_FETCH with no mem_resp -> S_DROP.
  - S_FETCH with mem_resp in the same cycle -> response discarded, go to S_FETCH (new address next cycle).
  - S_IDLE -> S_FETCH.
  - S_DROP -> stay in S_DROP.
  - A pop in the same cycle is ignored, since the buffer is flushed.
  - Redirect has priority over every push and pop.
- Buffer:
  - FIFO of DEPTH entries of {word, pc_next}.
  - Pop when instr_valid & instr_ready. Push and pop in the same cycle are legal, and count stays the same.
  - Overflow is impossible: a request issues only if count<DEPTH, and only pops can occur while it is outstanding.
  - instr_ready with an empty buffer is a no-op.
- Latency: from S_IDLE with an empty buffer and mem_resp arriving N cycles after mem_read rises, instr_valid rises on the edge after mem_resp (N+1 cycles after request start).
- Outputs are registered or derived from registered state only. There are no combinational paths from instr_ready or mem_resp to mem_read or mem_address.

Decomposition:
- Package lc3b_types:
  - reuse lc3b_word;
  - add typedef lc3b_fetch_state (S_IDLE, S_FETCH, S_DROP);
  - add constant LC3B_RESET_PC=16'h0000;
  - add typedef lc3b_fetch_entry (struct: word, pc_next).
- Sub-module fetch_fifo (parameter DEPTH; ports: push, pop, flush, din, dout, count, empty). The FSM and PC logic stay in lc3b_fetch_unit.

Test Plan:
- Reset, then mem_resp after 2-cycle latency with rdata 16'h1234; instr_ready=0.
  - Required: mem_address=0000 then 0002; buffer fills to 2; mem_read drops to 0 after the second response.
  - Required: instr=1234, instr_pc_next=0002, instr_valid=1 held.
- Memory answers every cycle and instr_ready=1 continuously.
  - Required: one instruction per cycle; mem_read stays 1; addresses 0000, 0002, 0004, ... with no gaps.
- Redirect to 16'h3001 while a request to 0004 is outstanding.
  - Required: the next mem_resp (rdata 16'hDEAD) is discarded; the next request is to 3000; instr_pc_next of the first delivered word is 3002; DEAD is never presented.
- Redirect in the same cycle as mem_resp, with the buffer holding 1 entry.
  - Required: the buffer is empty next cycle; the response is dropped; mem_address=redirect target.
- fetch_pc=FFFE.
  - Required: the fetched word has instr_pc_next=0000; the next request is to 0000.
- rst_n=0 for 1 cycle during S_FETCH, then a late mem_resp.
  - Required: the late response is ignored; fetch restarts at 0000; instr_valid=0 until the new response.
